// File: rtl/tlc_farm_sensor.sv
`default_nettype none
// ============================================================================
// Module   : tlc_farm_sensor
// Purpose  : Farm-road vehicle detector for the traffic-light controller.
//            Synchronises and debounces the raw loop input, counts waiting
//            vehicles, raises car_req until the controller shows farm green,
//            and flags a sticky fault on an illegal light code or on a
//            request starved for MAX_WAIT cycles.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            ena        - clock enable (synchroniser always runs)
//            loop_raw   - raw asynchronous loop sensor, 1 = vehicle present
//            light_farm - farm lights: 100 red, 010 yellow, 001 green
//            car_req    - registered request to the controller (input C)
//            car_count  - saturating count of vehicles waiting
//            fault      - sticky fault flag, cleared only by reset
// Revision : 1.0 - initial release
// ============================================================================
module tlc_farm_sensor #(
  parameter int DEBOUNCE = 4,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             loop_raw,
  input  logic [2:0]       light_farm,
  output logic             car_req,
  output logic [CNT_W-1:0] car_count,
  output logic             fault
);

  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVE   = 2'd2
  } state_t;

  // Synchroniser (never gated by ena)
  logic sync1_q, loop_s_q;

  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              loop_db_q, loop_db_d;
  logic              loop_db_dly_q, loop_db_dly_d;
  logic [CNT_W-1:0]  car_count_q, car_count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic              car_req_q, car_req_d;

  logic arr, green, illegal;

  // arr stays high across disabled cycles until the delayed copy catches up
  // on the next enabled cycle, so an arrival is never lost while ena=0.
  assign arr     = loop_db_q & ~loop_db_dly_q;
  assign green   = (light_farm == 3'b001);
  assign illegal = !(light_farm inside {3'b100, 3'b010, 3'b001});

  always_comb begin
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    loop_db_d     = loop_db_q;
    loop_db_dly_d = loop_db_dly_q;
    car_count_d   = car_count_q;
    wait_d        = wait_q;
    fault_d       = fault_q;

    if (ena) begin
      loop_db_dly_d = loop_db_q;

      // Debounce: flip loop_db after DEBOUNCE consecutive mismatching cycles
      if (loop_s_q != loop_db_q) begin
        if (db_cnt_q == DB_LAST) begin
          loop_db_d = loop_s_q;
          db_cnt_d  = '0;
        end else begin
          db_cnt_d  = db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_d = '0;
      end

      unique case (state_q)
        IDLE: begin
          if (arr) begin
            state_d     = REQUEST;
            car_count_d = CNT_W'(1);
            wait_d      = '0;
          end
        end
        REQUEST: begin
          if (green) begin
            // A simultaneous arrival is absorbed by this green phase
            state_d     = SERVE;
            car_count_d = '0;
          end else begin
            if (arr && (car_count_q != CNT_MAX)) begin
              car_count_d = car_count_q + 1'b1;
            end
            if (wait_q != WAIT_MAX) begin
              wait_d = wait_q + 1'b1;
              if (wait_d == WAIT_MAX) begin
                fault_d = 1'b1;
              end
            end
          end
        end
        SERVE: begin
          if (!green) begin
            if (loop_db_q) begin
              // Vehicle still on the loop when green ends: request again
              state_d     = REQUEST;
              car_count_d = CNT_W'(1);
              wait_d      = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (illegal) begin
        fault_d = 1'b1;
      end
    end

    car_req_d = (state_d == REQUEST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      loop_s_q      <= 1'b0;
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      loop_db_q     <= 1'b0;
      loop_db_dly_q <= 1'b0;
      car_count_q   <= '0;
      wait_q        <= '0;
      fault_q       <= 1'b0;
      car_req_q     <= 1'b0;
    end else begin
      sync1_q       <= loop_raw;
      loop_s_q      <= sync1_q;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      loop_db_q     <= loop_db_d;
      loop_db_dly_q <= loop_db_dly_d;
      car_count_q   <= car_count_d;
      wait_q        <= wait_d;
      fault_q       <= fault_d;
      car_req_q     <= car_req_d;
    end
  end

  assign car_req   = car_req_q;
  assign car_count = car_count_q;
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_tlc_farm_sensor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlc_farm_sensor
// Purpose  : Self-checking bench for tlc_farm_sensor: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlc_farm_sensor;

  localparam int DEBOUNCE = 4;
  localparam int MAX_WAIT = 64;
  localparam int CNT_W    = 4;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_GREEN = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             loop_raw;
  logic [2:0]       light_farm;
  logic             car_req;
  logic [CNT_W-1:0] car_count;
  logic             fault;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_pipe[$];   // two-stage delay of loop_raw; m_pipe[0] is the synced value
  int m_db, m_prev, m_run, m_phase, m_count, m_wait, m_fault;

  tlc_farm_sensor #(
    .DEBOUNCE(DEBOUNCE),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .loop_raw  (loop_raw),
    .light_farm(light_farm),
    .car_req   (car_req),
    .car_count (car_count),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe  = '{1'b0, 1'b0};
    m_db    = 0;
    m_prev  = 0;
    m_run   = 0;
    m_phase = M_IDLE;
    m_count = 0;
    m_wait  = 0;
    m_fault = 0;
  endtask

  // One clock edge of the intended behaviour, using the inputs present at the edge.
  task automatic model_edge();
    bit s_old;
    bit arrival;
    bit green;
    s_old = m_pipe[0];
    m_pipe.push_back(loop_raw);
    void'(m_pipe.pop_front());
    if (!ena) return;
    arrival = (m_db == 1) && (m_prev == 0);
    green   = (light_farm == 3'b001);
    case (m_phase)
      M_IDLE: if (arrival) begin
        m_phase = M_WAIT; m_count = 1; m_wait = 0;
      end
      M_WAIT: if (green) begin
        m_phase = M_GREEN; m_count = 0;
      end else begin
        if (arrival && m_count < CNT_SAT) m_count++;
        if (m_wait < MAX_WAIT) begin
          m_wait++;
          if (m_wait == MAX_WAIT) m_fault = 1;
        end
      end
      default: if (!green) begin
        if (m_db == 1) begin
          m_phase = M_WAIT; m_count = 1; m_wait = 0;
        end else begin
          m_phase = M_IDLE;
        end
      end
    endcase
    if (!(light_farm == 3'b100 || light_farm == 3'b010 || light_farm == 3'b001)) m_fault = 1;
    m_prev = m_db;
    if (s_old != m_db[0]) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_db  = s_old;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_model();
    chk_eq("car_req",   car_req,   (m_phase == M_WAIT) ? 1 : 0);
    chk_eq("car_count", car_count, m_count);
    chk_eq("fault",     fault,     m_fault);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_model();
    end
  endtask

  // Asserts reset between clock edges and checks the outputs drop immediately.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_eq({tag, "_req"},   car_req,   0);
    chk_eq({tag, "_count"}, car_count, 0);
    chk_eq({tag, "_fault"}, fault,     0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Steps until car_req rises; returns cycles taken, or limit+1 on timeout.
  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (car_req !== 1'b1 && n <= limit) begin
      step(1);
      n++;
    end
  endtask

  task automatic drive(input bit raw, input logic [2:0] lf, input bit en);
    loop_raw   = raw;
    light_farm = lf;
    ena        = en;
  endtask

  int n;
  int raw_hold, lf_hold;

  initial begin
    model_reset();
    drive(1'b0, 3'b100, 1'b1);
    rst_n = 1'b0;
    #2;
    do_reset("init");

    // Debounce: a 3-cycle blip is rejected, a held vehicle requests after 7 cycles
    drive(1'b1, 3'b100, 1'b1);
    step(3);
    loop_raw = 1'b0;
    step(10);
    chk_eq("t2_glitch_req", car_req, 0);
    loop_raw = 1'b1;
    wait_req(20, n);
    chk_eq("t2_latency", n, 7);

    // Handshake: two more arrivals, then green clears, then yellow idles
    for (int p = 0; p < 2; p++) begin
      loop_raw = 1'b0; step(8);
      loop_raw = 1'b1; step(8);
    end
    chk_eq("t3_count3", car_count, 3);
    loop_raw = 1'b0;
    step(8);
    light_farm = 3'b001;
    step(1);
    chk_eq("t3_green_req", car_req, 0);
    chk_eq("t3_green_cnt", car_count, 0);
    light_farm = 3'b010;
    step(3);
    chk_eq("t3_idle_req", car_req, 0);

    // Re-request: vehicle remains on the loop through green
    drive(1'b1, 3'b100, 1'b1);
    wait_req(20, n);
    chk_eq("t4_first_req", car_req, 1);
    light_farm = 3'b001;
    step(2);
    light_farm = 3'b010;
    step(1);
    chk_eq("t4_rereq", car_req, 1);
    chk_eq("t4_recount", car_count, 1);

    // Saturation and arrival coinciding with green
    light_farm = 3'b100;
    for (int p = 0; p < 20; p++) begin
      loop_raw = 1'b0; step(7);
      loop_raw = 1'b1; step(7);
    end
    chk_eq("t5_saturate", car_count, CNT_SAT);
    loop_raw = 1'b0; step(7);
    loop_raw = 1'b1; step(6);   // loop_db has just risen: arrival pending this cycle
    light_farm = 3'b001;
    step(1);
    chk_eq("t5_simul_cnt", car_count, 0);
    chk_eq("t5_simul_req", car_req, 0);
    light_farm = 3'b100;
    step(1);
    chk_eq("t5_serve_exit", car_count, 1);

    // Reset in the middle of a request
    #2;
    do_reset("t1_reset");

    // Watchdog
    drive(1'b1, 3'b100, 1'b1);
    wait_req(20, n);
    step(MAX_WAIT - 1);
    chk_eq("t6_wd_before", fault, 0);
    step(1);
    chk_eq("t6_wd_fault", fault, 1);
    chk_eq("t6_wd_req", car_req, 1);
    step(5);
    #2;
    do_reset("t6_reset_a");

    // Illegal light code
    light_farm = 3'b011;
    step(1);
    chk_eq("t6_illegal", fault, 1);
    #2;
    do_reset("t6_reset_b");

    // Clock enable low freezes everything
    drive(1'b1, 3'b100, 1'b1);
    wait_req(20, n);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      loop_raw   = 1'($urandom);
      light_farm = (i == 4) ? 3'b111 : 3'b001;
      step(1);
      chk_eq("t6_frozen_req", car_req, 1);
      chk_eq("t6_frozen_cnt", car_count, 1);
      chk_eq("t6_frozen_flt", fault, 0);
    end
    #2;
    do_reset("rand_reset");

    // Randomized traffic against the model
    raw_hold = 0;
    lf_hold  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (raw_hold == 0) begin
        loop_raw = 1'($urandom);
        raw_hold = $urandom_range(1, 14);
      end
      raw_hold--;
      if (lf_hold == 0) begin
        case ($urandom_range(0, 99)) inside
          [0:59]:  light_farm = 3'b100;
          [60:79]: light_farm = 3'b010;
          [80:98]: light_farm = 3'b001;
          default: light_farm = 3'($urandom);
        endcase
        lf_hold = $urandom_range(1, 30);
      end
      lf_hold--;
      ena = ($urandom_range(0, 9) != 0);
      step(1);
      if (c % 750 == 749) begin
        #2;
        do_reset("rand_mid_reset");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
